slice_bit_packer: RTL and testbench
===================================

# slice_bit_packer

Packs the variable-length codewords produced by the slice VLC stages into a 32-bit word stream. Bit order is MSB-first. The block sits directly downstream of the VLC encoders and is gated by the slice sequencer's `*_vlc_reset`, `*_vlc_output_enable` and `*_vlc_output_flush` strobes. It pads the final word at slice end and reports the slice byte count. It is sequence-timed: there is no backpressure, and at most one codeword is accepted per cycle.

## Interface
- `CODE_W`, default 32: maximum codeword length and width of `code_value`.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `pack_enable`  in  1  level run enable, driven by `ac_vlc_reset`. When 0, the block is synchronously held idle.
- `code_valid`  in  1  codeword present this cycle, driven by `output_enable`.
- `code_value`  in  `CODE_W`  codeword right-justified in the low `code_len` bits. Bit `code_len-1` is sent first.
- `code_len`  in  6  codeword length, 0..32. A value above 32 is clamped to 32.
- `flush`  in  1  single-cycle end-of-slice strobe.
- `out_valid`  out  1  `out_word` is valid this cycle.
- `out_word`  out  32  packed word. Bit 31 is the first bit.
- `flush_done`  out  1  single-cycle pulse that marks the end of the slice.
- `out_byte_count`  out  32  bytes emitted this slice (4 per word).

## Operation
- Holds a 64-bit accumulator `acc` and a 7-bit fill count `fill`, with 0 ≤ `fill` ≤ 63 at all times.
- States:
  - IDLE: leaves IDLE when `pack_enable`=1. On IDLE→RUN, `acc`, `fill` and `out_byte_count` are cleared.
  - RUN: appends codewords. `flush` moves to DRAIN if the remainder after this cycle's emit is non-zero, otherwise to DONE.
  - DRAIN: emits the zero-padded remainder, then moves to DONE.
  - DONE: ignores `code_valid` and `flush` until `pack_enable`=0.
- `pack_enable`=0 in any state forces IDLE on the next edge and clears `acc`, `fill`, `out_valid` and `flush_done`. `out_byte_count` holds its value in IDLE.
- RUN append: when `code_valid`=1 and `len`>0, the code's `len` bits are placed immediately after the current `fill` bits, and `fill += len`. `len`=0 is a no-op.
- RUN emit (evaluated after the append):
  - If `fill` ≥ 32, the top 32 bits go to `out_word`, `acc` shifts left by 32, `fill -= 32`, and `out_byte_count += 4`.
  - At most one word is emitted per cycle. No overflow is possible, because `fill` ≤ 31 + 32 after every cycle.
- Flush in RUN, with any same-cycle code appended first:
  - If the post-emit `fill` is 0 and a word was emitted that cycle, that word carries `flush_done`.
  - If `fill` is 0 and no word was emitted, `flush_done` pulses alone with `out_valid`=0.
  - If `fill` > 0, DRAIN emits the remainder, MSB-aligned and zero-padded to 32 bits, with `flush_done`=1, and `out_byte_count += 4`.
- Counters wrap modulo 2^32.
- `flush` while `pack_enable`=0 is ignored.

## Timing
- All outputs are registered.
- Reset values: `out_valid`=0, `out_word`=0, `flush_done`=0, `out_byte_count`=0, state=IDLE.
- Latency: a word completed by a code at edge N appears as `out_valid` in the cycle after edge N, i.e. 1 cycle.
- Flush at edge N:
  - The remainder word and `flush_done` appear after edge N+1.
  - In the no-remainder case, `flush_done` appears after edge N.
- `out_valid` and `flush_done` are each high for exactly one cycle per event.
- `out_word` holds its last value while `out_valid`=0.
- Simultaneous `code_valid` + `flush`: the code is included in the flushed data.
- Asserting `reset_n` mid-slice discards all partial data immediately.

## Configuration
- `SLICE_BIT_PACKER_BIT_COUNT_EN`: when defined, adds output `out_bit_count` (32 bits, registered).
  - It counts exact payload bits appended this slice, excluding padding.
  - It clears on IDLE→RUN, holds in IDLE and DONE, and resets to 0.
- When undefined, the port and its counter are absent. All other behaviour is identical.

## Test plan
- Four codes with `len`=8 and value 0xA5 on consecutive cycles → one `out_word`=0xA5A5A5A5, one cycle after the 4th code; `out_byte_count`=4.
- A 3-bit code 0b101 then `flush` → `out_word`=0xA0000000 with `flush_done`=1, two cycles after the flush; `out_byte_count`=4.
- Code 0x7FFFFFFF with `len`=31, then code 0x00000001 with `len`=32 together with `flush`:
  - First, `out_word`=0xFFFFFFFE with `flush_done`=0.
  - Next cycle, `out_word`=0x00000002 with `flush_done`=1.
  - `out_byte_count`=8.
- Four codes with `len`=8 and value 0xFF, the 4th with `flush`:
  - `out_word`=0xFFFFFFFF and `flush_done` appear in the same cycle.
  - No further word follows.
  - `code_valid` in DONE produces no output.
- `pack_enable` dropped with `fill`=20 → no word emitted. Re-enable followed by a `len`=32 code 0x12345678 → `out_word`=0x12345678 and `out_byte_count`=4.
- `len`=0 codes interleaved with `len`=16 codes 0xBEEF and 0xCAFE → `out_word`=0xBEEFCAFE. With the macro defined, `out_bit_count`=32.

Source files
------------

// File: rtl/slice_bit_packer.sv
// slice_bit_packer: MSB-first codeword packer into a 32-bit word stream.
// Optional SLICE_BIT_PACKER_BIT_COUNT_EN adds out_bit_count (payload bits).
module slice_bit_packer #(
  parameter int CODE_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pack_enable,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_value,
  input  logic [5:0]        code_len,
  input  logic              flush,
  output logic              out_valid,
  output logic [31:0]       out_word,
  output logic              flush_done,
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
  output logic [31:0]       out_bit_count,
`endif
  output logic [31:0]       out_byte_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [6:0]  fill_q, fill_d;
  logic        vld_q, vld_d;
  logic [31:0] word_q, word_d;
  logic        fd_q, fd_d;
  logic [31:0] bc_q, bc_d;
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
  logic [31:0] bits_q, bits_d;
`endif

  logic [5:0]  len_c;
  logic [63:0] code_ext;
  logic [63:0] mask;
  logic [6:0]  sh;
  logic [63:0] placed;
  logic [63:0] acc_a;
  logic [6:0]  fill_a;

  // Clamp length, mask code to its length and MSB-align it after fill bits.
  always_comb begin
    len_c    = (code_len > 6'd32) ? 6'd32 : code_len;
    code_ext = {{(64-CODE_W){1'b0}}, code_value};
    mask     = (64'd1 << len_c) - 64'd1;
    sh       = 7'd64 - fill_q - {1'b0, len_c};
    placed   = (code_ext & mask) << sh;
  end

  // Next-state: FSM, append, single-word emit, flush and drain.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    vld_d   = 1'b0;
    word_d  = word_q;
    fd_d    = 1'b0;
    bc_d    = bc_q;
    acc_a   = acc_q;
    fill_a  = fill_q;
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
    bits_d  = bits_q;
`endif
    if (!pack_enable) begin
      state_d = IDLE;
      acc_d   = '0;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          acc_d   = '0;
          fill_d  = '0;
          bc_d    = '0;
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
          bits_d  = '0;
`endif
        end
        RUN: begin
          if (code_valid && len_c != 6'd0) begin
            acc_a  = acc_q | placed;
            fill_a = fill_q + {1'b0, len_c};
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
            bits_d = bits_q + {26'd0, len_c};
`endif
          end
          if (fill_a >= 7'd32) begin
            vld_d  = 1'b1;
            word_d = acc_a[63:32];
            acc_a  = acc_a << 32;
            fill_a = fill_a - 7'd32;
            bc_d   = bc_q + 32'd4;
          end
          acc_d  = acc_a;
          fill_d = fill_a;
          if (flush) begin
            if (fill_a == 7'd0) begin
              fd_d    = 1'b1;
              state_d = DONE;
            end else begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          vld_d   = 1'b1;
          word_d  = acc_q[63:32];
          fd_d    = 1'b1;
          bc_d    = bc_q + 32'd4;
          acc_d   = '0;
          fill_d  = '0;
          state_d = DONE;
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset drops any partial slice data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
      vld_q   <= 1'b0;
      word_q  <= '0;
      fd_q    <= 1'b0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      vld_q   <= vld_d;
      word_q  <= word_d;
      fd_q    <= fd_d;
      bc_q    <= bc_d;
    end
  end

`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
  // Payload bit counter, excluding drain padding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign out_bit_count = bits_q;
`endif

  assign out_valid      = vld_q;
  assign out_word       = word_q;
  assign flush_done     = fd_q;
  assign out_byte_count = bc_q;

endmodule

// File: tb/tb_slice_bit_packer.sv
// tb_slice_bit_packer: vector table plus scoreboard for slice_bit_packer.
// Expected output events are queued at drive time and popped on output.
module tb_slice_bit_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        pack_enable = 1'b0;
  logic        code_valid = 1'b0;
  logic [31:0] code_value = '0;
  logic [5:0]  code_len = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_word;
  logic        flush_done;
  logic [31:0] out_byte_count;
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
  logic [31:0] out_bit_count;
`endif

  slice_bit_packer #(.CODE_W(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pack_enable    (pack_enable),
    .code_valid     (code_valid),
    .code_value     (code_value),
    .code_len       (code_len),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_word       (out_word),
    .flush_done     (flush_done),
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
    .out_bit_count  (out_bit_count),
`endif
    .out_byte_count (out_byte_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] w;
    bit          v;
    bit          f;
    int          e;
  } exp_t;

  typedef struct {
    bit          pe;
    bit          cv;
    logic [31:0] val;
    logic [5:0]  len;
    bit          fl;
    int          bc;
    int          ne;
    exp_t        x0;
    exp_t        x1;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t NX;
  vec_t tv[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @cyc %0d", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t X(logic [31:0] w, bit v, bit f, int d);
    exp_t x;
    x.w = w;
    x.v = v;
    x.f = f;
    x.e = d;
    return x;
  endfunction

  function automatic vec_t V(bit pe, bit cv, logic [31:0] val,
                             logic [5:0] len, bit fl, int bc,
                             int ne, exp_t a, exp_t b);
    vec_t r;
    r.pe  = pe;
    r.cv  = cv;
    r.val = val;
    r.len = len;
    r.fl  = fl;
    r.bc  = bc;
    r.ne  = ne;
    r.x0  = a;
    r.x1  = b;
    return r;
  endfunction

  // Scoreboard monitor: sampled on the falling edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid || flush_done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=v%0d/fd%0d/%h required=none",
                   out_valid, flush_done, out_word);
        end else begin
          mon_e = sb.pop_front();
          chk("out_valid", 32'(out_valid), 32'(mon_e.v));
          if (mon_e.v) chk("out_word", out_word, mon_e.w);
          chk("flush_done", 32'(flush_done), 32'(mon_e.f));
          chk("event_edge", 32'(cyc), 32'(mon_e.e));
        end
      end else if (sb.size() > 0 && sb[0].e <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_output actual=none required=v%0d/fd%0d/%h",
                 mon_e.v, mon_e.f, mon_e.w);
      end
    end
  end

  task automatic apply(vec_t v);
    exp_t x;
    pack_enable = v.pe;
    code_valid  = v.cv;
    code_value  = v.val;
    code_len    = v.len;
    flush       = v.fl;
    if (v.ne > 0) begin
      x = v.x0;
      x.e = cyc + 1 + v.x0.e;
      sb.push_back(x);
    end
    if (v.ne > 1) begin
      x = v.x1;
      x.e = cyc + 1 + v.x1.e;
      sb.push_back(x);
    end
    @(negedge clock);
    #1;
    if (v.bc >= 0) chk("byte_count", out_byte_count, 32'(v.bc));
  endtask

  initial begin
    NX = X(32'h0, 1'b0, 1'b0, 0);

    // slice 1: four 0xA5 bytes, flush with empty remainder, code in DONE
    tv.push_back(V(1, 0, 32'h0,        6'd0,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'hA5,       6'd8,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'hA5,       6'd8,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'hA5,       6'd8,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'hA5,       6'd8,  0, 4, 1,
                   X(32'hA5A5A5A5, 1, 0, 0), NX));
    tv.push_back(V(1, 0, 32'h0,        6'd0,  1, 4, 1,
                   X(32'h0, 0, 1, 0), NX));
    tv.push_back(V(1, 1, 32'hFF,       6'd8,  0, 4, 0, NX, NX));
    tv.push_back(V(0, 0, 32'h0,        6'd0,  0, 4, 0, NX, NX));
    // slice 2: 3-bit code then flush drains a padded word
    tv.push_back(V(1, 0, 32'h0,        6'd0,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h5,        6'd3,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 0, 32'h0,        6'd0,  1, 0, 1,
                   X(32'hA0000000, 1, 1, 1), NX));
    tv.push_back(V(1, 0, 32'h0,        6'd0,  0, 4, 0, NX, NX));
    tv.push_back(V(0, 0, 32'h0,        6'd0,  0, 4, 0, NX, NX));
    // slice 3: 31 + 32 bits with flush on the second code
    tv.push_back(V(1, 0, 32'h0,        6'd0,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h7FFFFFFF, 6'd31, 0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h00000001, 6'd32, 1, 4, 2,
                   X(32'hFFFFFFFE, 1, 0, 0), X(32'h00000002, 1, 1, 1)));
    tv.push_back(V(1, 0, 32'h0,        6'd0,  0, 8, 0, NX, NX));
    tv.push_back(V(0, 0, 32'h0,        6'd0,  0, 8, 0, NX, NX));
    // slice 4: 0xFF bytes with junk high bits, flush on the 4th
    tv.push_back(V(1, 0, 32'h0,        6'd0,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h123456FF, 6'd8,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h123456FF, 6'd8,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h123456FF, 6'd8,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h123456FF, 6'd8,  1, 4, 1,
                   X(32'hFFFFFFFF, 1, 1, 0), NX));
    tv.push_back(V(1, 1, 32'hFF,       6'd8,  0, 4, 0, NX, NX));
    tv.push_back(V(1, 1, 32'hFFFFFFFF, 6'd32, 1, 4, 0, NX, NX));
    tv.push_back(V(0, 0, 32'h0,        6'd0,  0, 4, 0, NX, NX));
    // slice 5: len=0 no-ops around 0xBEEF/0xCAFE, then clamped len
    tv.push_back(V(1, 0, 32'h0,        6'd0,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'hFFFF,     6'd0,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'hBEEF,     6'd16, 0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h1234,     6'd0,  0, 0, 0, NX, NX));
    tv.push_back(V(1, 1, 32'hCAFE,     6'd16, 0, 4, 1,
                   X(32'hBEEFCAFE, 1, 0, 0), NX));
    tv.push_back(V(1, 1, 32'hFFFFFFFF, 6'd0,  0, 4, 0, NX, NX));
    tv.push_back(V(1, 1, 32'h89ABCDEF, 6'd40, 0, 8, 1,
                   X(32'h89ABCDEF, 1, 0, 0), NX));
    tv.push_back(V(1, 0, 32'h0,        6'd0,  1, 8, 1,
                   X(32'h0, 0, 1, 0), NX));
    tv.push_back(V(0, 0, 32'h0,        6'd0,  0, 8, 0, NX, NX));

    // reset values
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_byte_count", out_byte_count, 32'd0);
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
    chk("rst_bit_count", out_bit_count, 32'd0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) apply(tv[i]);
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
    chk("bit_count_slice5", out_bit_count, 32'd64);
`endif

    // enable dropped with 20 bits pending, flush while disabled ignored
    apply(V(1, 0, 32'h0,      6'd0,  0, 0, 0, NX, NX));
    apply(V(1, 1, 32'hABCDE,  6'd20, 0, 0, 0, NX, NX));
    for (int i = 0; i < 3; i++)
      apply(V(0, 0, 32'h0,    6'd0,  1, 0, 0, NX, NX));
    apply(V(1, 0, 32'h0,      6'd0,  0, 0, 0, NX, NX));
    apply(V(1, 1, 32'h12345678, 6'd32, 0, 4, 1,
            X(32'h12345678, 1, 0, 0), NX));
    apply(V(1, 0, 32'h0,      6'd0,  0, 4, 0, NX, NX));
`ifdef SLICE_BIT_PACKER_BIT_COUNT_EN
    chk("bit_count_reenable", out_bit_count, 32'd32);
`endif

    // asynchronous reset mid-slice discards partial data
    apply(V(1, 1, 32'hDEAD,   6'd16, 0, 4, 0, NX, NX));
    reset_n = 1'b0;
    #1;
    chk("midrst_out_word", out_word, 32'd0);
    chk("midrst_byte_count", out_byte_count, 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    apply(V(1, 0, 32'h0,      6'd0,  0, 0, 0, NX, NX));
    apply(V(1, 1, 32'h0F0F0F0F, 6'd32, 0, 4, 1,
            X(32'h0F0F0F0F, 1, 0, 0), NX));
    apply(V(1, 0, 32'h0,      6'd0,  1, 4, 1,
            X(32'h0, 0, 1, 0), NX));
    apply(V(0, 0, 32'h0,      6'd0,  0, 4, 0, NX, NX));
    apply(V(0, 0, 32'h0,      6'd0,  0, 4, 0, NX, NX));

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
